// File: rtl/ccff_bitstream_loader_if.sv
// Word handshake between a bitstream source and ccff_bitstream_loader.
// The host drives din/din_valid; the loader answers with din_ready.
interface ccff_bitstream_loader_if;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serializes 8-bit bitstream words MSB-first onto a configuration-chain head, gating the chain clock per bit.
// Optional running CRC-16-CCITT of delivered bits is built when CCFF_LOADER_CRC_EN is defined.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                      prog_clk,
    input  logic                      pReset,
    input  logic                      start,
    input  logic                      abort,
    ccff_bitstream_loader_if.slave    s_in,
    output logic                      ccff_head,
    output logic                      prog_clk_en,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          bits_loaded,
    output logic [15:0]               crc_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Wide enough for bit_count + bits_left without wrapping, even for tiny chains.
    localparam int FILL_W = CNT_W + 4;

    state_t           r_state;
    logic [7:0]       r_shreg;
    logic [3:0]       r_bits_left;
    logic [CNT_W-1:0] r_bit_count;
    logic             r_ccff_head;
    logic             r_prog_clk_en;

    state_t           w_state_next;
    logic [7:0]       w_shreg_next;
    logic [3:0]       w_bits_left_next;
    logic [CNT_W-1:0] w_bit_count_next;
    logic             w_ccff_head_next;
    logic             w_prog_clk_en_next;

    logic [FILL_W-1:0] w_fill;
    logic              w_din_ready;
    logic              w_pop;
    logic              w_accept;
    logic              w_start_ok;

    assign w_fill      = FILL_W'(r_bit_count) + FILL_W'(r_bits_left);
    assign w_din_ready = (r_state == S_LOAD) && (r_bits_left <= 4'd1)
                         && (w_fill < FILL_W'(CHAIN_LEN));
    assign w_pop       = (r_state == S_LOAD) && (r_bits_left != 4'd0)
                         && (r_bit_count < CNT_W'(CHAIN_LEN));
    assign w_accept    = s_in.din_valid && w_din_ready;
    assign w_start_ok  = start && (r_state != S_LOAD);

    always_comb begin
        w_state_next       = r_state;
        w_shreg_next       = r_shreg;
        w_bits_left_next   = r_bits_left;
        w_bit_count_next   = r_bit_count;
        w_ccff_head_next   = 1'b0;
        w_prog_clk_en_next = 1'b0;

        if (abort) begin
            w_state_next     = S_IDLE;
            w_shreg_next     = 8'h00;
            w_bits_left_next = 4'd0;
            w_bit_count_next = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        w_state_next     = S_LOAD;
                        w_shreg_next     = 8'h00;
                        w_bits_left_next = 4'd0;
                        w_bit_count_next = '0;
                    end
                end
                S_LOAD: begin
                    if (w_pop) begin
                        w_ccff_head_next   = r_shreg[7];
                        w_prog_clk_en_next = 1'b1;
                        w_shreg_next       = {r_shreg[6:0], 1'b0};
                        w_bits_left_next   = r_bits_left - 4'd1;
                        w_bit_count_next   = r_bit_count + CNT_W'(1);
                        // Unused LSBs of a partial final word are dropped here.
                        if (r_bit_count == CNT_W'(CHAIN_LEN - 1)) begin
                            w_state_next     = S_DONE;
                            w_bits_left_next = 4'd0;
                        end
                    end
                    // Overrides the pop update so the next word follows without a bubble.
                    if (w_accept) begin
                        w_shreg_next     = s_in.din;
                        w_bits_left_next = 4'd8;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_state       <= S_IDLE;
            r_shreg       <= 8'h00;
            r_bits_left   <= 4'd0;
            r_bit_count   <= '0;
            r_ccff_head   <= 1'b0;
            r_prog_clk_en <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_shreg       <= w_shreg_next;
            r_bits_left   <= w_bits_left_next;
            r_bit_count   <= w_bit_count_next;
            r_ccff_head   <= w_ccff_head_next;
            r_prog_clk_en <= w_prog_clk_en_next;
        end
    end

`ifdef CCFF_LOADER_CRC_EN
    localparam logic [15:0] CRC_POLY = 16'h1021;

    logic [15:0] r_crc;
    logic [15:0] w_crc_next;
    logic [15:0] w_crc_step;
    logic        w_crc_fb;

    // One MSB-first CRC step using the bit being popped this cycle.
    assign w_crc_fb      = r_crc[15] ^ r_shreg[7];
    assign w_crc_step[0] = w_crc_fb;
    generate
        for (genvar gi = 1; gi < 16; gi++) begin : g_crc
            assign w_crc_step[gi] = r_crc[gi-1] ^ (w_crc_fb & CRC_POLY[gi]);
        end
    endgenerate

    always_comb begin
        w_crc_next = r_crc;
        if (!abort) begin
            if (w_start_ok) begin
                w_crc_next = 16'hFFFF;
            end else if (w_pop) begin
                w_crc_next = w_crc_step;
            end
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_crc <= 16'h0000;
        end else begin
            r_crc <= w_crc_next;
        end
    end

    assign crc_out = r_crc;
`else
    assign crc_out = 16'h0000;
`endif

    assign s_in.din_ready = w_din_ready;
    assign ccff_head      = r_ccff_head;
    assign prog_clk_en    = r_prog_clk_en;
    assign busy           = (r_state == S_LOAD);
    assign done           = (r_state == S_DONE);
    assign bits_loaded    = r_bit_count;

endmodule
